mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 68 ++++++
 rtl/mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the fetch port, the load/store port, the memory command/response
// bus and the busy flag of mem_arbiter into one interface.
//
// Signal summary:
//   if_req, if_addr                      fetch request and word address
//   if_gnt, if_valid, if_err, if_rdata   fetch grant / completion / timeout / data
//   ls_req, ls_we_re, ls_mask,
//   ls_addr, ls_wdata                    load/store command (ls_we_re=1 writes)
//   ls_gnt, ls_valid, ls_err, ls_rdata   load/store grant / completion / timeout / data
//   mem_request, mem_we_re, mem_mask,
//   mem_address, mem_data_in             registered memory command
//   mem_valid, mem_data_out              memory response
//   busy                                 arbiter is not idle
//
// Modports:
//   master - the arbiter's view (it drives the grants, completions and memory command)
//   slave  - the environment's view (requesters plus memory)
interface mem_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic              if_err;
  logic [31:0]       if_rdata;

  logic              ls_req;
  logic              ls_we_re;
  logic [3:0]        ls_mask;
  logic [ADDR_W-1:0] ls_addr;
  logic [31:0]       ls_wdata;
  logic              ls_gnt;
  logic              ls_valid;
  logic              ls_err;
  logic [31:0]       ls_rdata;

  logic              mem_request;
  logic              mem_we_re;
  logic [3:0]        mem_mask;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_data_in;
  logic              mem_valid;
  logic [31:0]       mem_data_out;

  logic              busy;

  modport master (
    input  if_req, if_addr,
    output if_gnt, if_valid, if_err, if_rdata,
    input  ls_req, ls_we_re, ls_mask, ls_addr, ls_wdata,
    output ls_gnt, ls_valid, ls_err, ls_rdata,
    output mem_request, mem_we_re, mem_mask, mem_address, mem_data_in,
    input  mem_valid, mem_data_out,
    output busy
  );

  modport slave (
    output if_req, if_addr,
    input  if_gnt, if_valid, if_err, if_rdata,
    output ls_req, ls_we_re, ls_mask, ls_addr, ls_wdata,
    input  ls_gnt, ls_valid, ls_err, ls_rdata,
    input  mem_request, mem_we_re, mem_mask, mem_address, mem_data_in,
    output mem_valid, mem_data_out,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port memory between an instruction-fetch requester and a
// load/store requester. One transaction is outstanding at a time, and each
// transaction walks IDLE -> ISSUE -> WAIT -> IDLE. Ties alternate between the
// requesters, and a transaction whose memory never answers is aborted after
// TIMEOUT wait cycles with an error completion.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - mem_arbiter_if.master: requester handshakes, memory bus, busy
//
// Parameters:
//   ADDR_W  - memory word-address width
//   TIMEOUT - wait cycles before an unanswered access is aborted (2..255)
module mem_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 15
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
  typedef enum logic {OWNER_IF, OWNER_LS} owner_e;

  localparam logic [7:0] TimeoutCount = 8'(TIMEOUT);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [7:0]        count_q, count_d;
  logic [7:0]        countNext;
  logic              memRequest_q, memRequest_d;
  logic              memWe_q, memWe_d;
  logic [3:0]        memMask_q, memMask_d;
  logic [ADDR_W-1:0] memAddress_q, memAddress_d;
  logic [31:0]       memDataIn_q, memDataIn_d;
  logic              ifValid_q, ifValid_d;
  logic              ifErr_q, ifErr_d;
  logic [31:0]       ifRdata_q, ifRdata_d;
  logic              lsValid_q, lsValid_d;
  logic              lsErr_q, lsErr_d;
  logic [31:0]       lsRdata_q, lsRdata_d;
  logic              ifGnt;
  logic              lsGnt;

  // The wait counter saturates so a very large TIMEOUT can never wrap it.
  assign countNext = (count_q == 8'hFF) ? count_q : count_q + 8'd1;

  // State register plus every registered output. owner_q doubles as the
  // "granted last" memory used to break ties, and it resets to fetch so the
  // load/store port wins the very first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= OWNER_IF;
      count_q      <= 8'd0;
      memRequest_q <= 1'b0;
      memWe_q      <= 1'b0;
      memMask_q    <= 4'h0;
      memAddress_q <= '0;
      memDataIn_q  <= 32'd0;
      ifValid_q    <= 1'b0;
      ifErr_q      <= 1'b0;
      ifRdata_q    <= 32'd0;
      lsValid_q    <= 1'b0;
      lsErr_q      <= 1'b0;
      lsRdata_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      count_q      <= count_d;
      memRequest_q <= memRequest_d;
      memWe_q      <= memWe_d;
      memMask_q    <= memMask_d;
      memAddress_q <= memAddress_d;
      memDataIn_q  <= memDataIn_d;
      ifValid_q    <= ifValid_d;
      ifErr_q      <= ifErr_d;
      ifRdata_q    <= ifRdata_d;
      lsValid_q    <= lsValid_d;
      lsErr_q      <= lsErr_d;
      lsRdata_q    <= lsRdata_d;
    end
  end

  // Next-state and output logic. The memory command is loaded at grant time
  // so it is already on the bus during ISSUE, and it is left untouched until
  // the next grant so it stays stable for the whole WAIT. Valid and err
  // default low so a completion is always a single-cycle pulse, and only the
  // latched owner's completion is ever touched. A response that coincides
  // with the last timeout cycle still counts as a normal completion.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    count_d      = count_q;
    memRequest_d = 1'b0;
    memWe_d      = memWe_q;
    memMask_d    = memMask_q;
    memAddress_d = memAddress_q;
    memDataIn_d  = memDataIn_q;
    ifValid_d    = 1'b0;
    ifErr_d      = 1'b0;
    ifRdata_d    = ifRdata_q;
    lsValid_d    = 1'b0;
    lsErr_d      = 1'b0;
    lsRdata_d    = lsRdata_q;
    ifGnt        = 1'b0;
    lsGnt        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.ls_req && (!bus.if_req || owner_q == OWNER_IF)) begin
          lsGnt        = 1'b1;
          owner_d      = OWNER_LS;
          memRequest_d = 1'b1;
          memWe_d      = bus.ls_we_re;
          memMask_d    = bus.ls_mask;
          memAddress_d = bus.ls_addr;
          memDataIn_d  = bus.ls_wdata;
          state_d      = ISSUE;
        end else if (bus.if_req) begin
          ifGnt        = 1'b1;
          owner_d      = OWNER_IF;
          memRequest_d = 1'b1;
          memWe_d      = 1'b0;
          memMask_d    = 4'hF;
          memAddress_d = bus.if_addr;
          memDataIn_d  = 32'd0;
          state_d      = ISSUE;
        end
      end

      ISSUE: begin
        count_d = 8'd0;
        state_d = WAIT;
      end

      WAIT: begin
        if (bus.mem_valid) begin
          state_d = IDLE;
          if (owner_q == OWNER_IF) begin
            ifValid_d = 1'b1;
            if (!memWe_q) begin
              ifRdata_d = bus.mem_data_out;
            end
          end else begin
            lsValid_d = 1'b1;
            if (!memWe_q) begin
              lsRdata_d = bus.mem_data_out;
            end
          end
        end else if (countNext == TimeoutCount) begin
          state_d = IDLE;
          count_d = countNext;
          if (owner_q == OWNER_IF) begin
            ifValid_d = 1'b1;
            ifErr_d   = 1'b1;
            ifRdata_d = 32'd0;
          end else begin
            lsValid_d = 1'b1;
            lsErr_d   = 1'b1;
            lsRdata_d = 32'd0;
          end
        end else begin
          count_d = countNext;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Grants are combinational, so they are also gated by reset to keep every
  // output low while reset is held.
  assign bus.if_gnt      = ifGnt & rst;
  assign bus.ls_gnt      = lsGnt & rst;
  assign bus.if_valid    = ifValid_q;
  assign bus.if_err      = ifErr_q;
  assign bus.if_rdata    = ifRdata_q;
  assign bus.ls_valid    = lsValid_q;
  assign bus.ls_err      = lsErr_q;
  assign bus.ls_rdata    = lsRdata_q;
  assign bus.mem_request = memRequest_q;
  assign bus.mem_we_re   = memWe_q;
  assign bus.mem_mask    = memMask_q;
  assign bus.mem_address = memAddress_q;
  assign bus.mem_data_in = memDataIn_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: a table of per-cycle vectors for the
// fetch, load, store and stray-response cases, followed by hand-written
// sequences for tie alternation, timeout and reset during WAIT.
module tb_mem_arbiter;

  localparam int ADDR_W  = 12;
  localparam int TIMEOUT = 15;
  localparam int NumVecs = 15;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  mem_arbiter_if #(.ADDR_W(ADDR_W)) bus();

  mem_arbiter #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // One record per clock cycle: inputs driven at the falling edge and the
  // outputs expected just after them. Gnt/valid/err pairs are {if, ls}.
  typedef struct {
    string             name;
    logic              ifReq;
    logic [ADDR_W-1:0] ifAddr;
    logic              lsReq;
    logic              lsWe;
    logic [3:0]        lsMask;
    logic [ADDR_W-1:0] lsAddr;
    logic [31:0]       lsWdata;
    logic              memValid;
    logic [31:0]       memDataOut;
    logic [1:0]        expGnt;
    logic [1:0]        expValid;
    logic [1:0]        expErr;
    logic [31:0]       expIfRdata;
    logic [31:0]       expLsRdata;
    logic              expMemReq;
    logic              expMemWe;
    logic [3:0]        expMemMask;
    logic [ADDR_W-1:0] expMemAddr;
    logic [31:0]       expMemDin;
    logic              expBusy;
  } vector_t;

  vector_t vecs [NumVecs];

  // Single comparison point: counts every check and reports a mismatch.
  task automatic checkSignal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    bus.if_req       = 1'b0;
    bus.if_addr      = '0;
    bus.ls_req       = 1'b0;
    bus.ls_we_re     = 1'b0;
    bus.ls_mask      = 4'h0;
    bus.ls_addr      = '0;
    bus.ls_wdata     = 32'd0;
    bus.mem_valid    = 1'b0;
    bus.mem_data_out = 32'd0;
  endtask

  task automatic applyStimulus(input vector_t v);
    bus.if_req       = v.ifReq;
    bus.if_addr      = v.ifAddr;
    bus.ls_req       = v.lsReq;
    bus.ls_we_re     = v.lsWe;
    bus.ls_mask      = v.lsMask;
    bus.ls_addr      = v.lsAddr;
    bus.ls_wdata     = v.lsWdata;
    bus.mem_valid    = v.memValid;
    bus.mem_data_out = v.memDataOut;
  endtask

  task automatic checkOutput(input vector_t v);
    checkSignal({v.name, ".if_gnt"},      32'(bus.if_gnt),      32'(v.expGnt[1]));
    checkSignal({v.name, ".ls_gnt"},      32'(bus.ls_gnt),      32'(v.expGnt[0]));
    checkSignal({v.name, ".if_valid"},    32'(bus.if_valid),    32'(v.expValid[1]));
    checkSignal({v.name, ".ls_valid"},    32'(bus.ls_valid),    32'(v.expValid[0]));
    checkSignal({v.name, ".if_err"},      32'(bus.if_err),      32'(v.expErr[1]));
    checkSignal({v.name, ".ls_err"},      32'(bus.ls_err),      32'(v.expErr[0]));
    checkSignal({v.name, ".if_rdata"},    bus.if_rdata,         v.expIfRdata);
    checkSignal({v.name, ".ls_rdata"},    bus.ls_rdata,         v.expLsRdata);
    checkSignal({v.name, ".mem_request"}, 32'(bus.mem_request), 32'(v.expMemReq));
    checkSignal({v.name, ".mem_we_re"},   32'(bus.mem_we_re),   32'(v.expMemWe));
    checkSignal({v.name, ".mem_mask"},    32'(bus.mem_mask),    32'(v.expMemMask));
    checkSignal({v.name, ".mem_address"}, 32'(bus.mem_address), 32'(v.expMemAddr));
    checkSignal({v.name, ".mem_data_in"}, bus.mem_data_in,      v.expMemDin);
    checkSignal({v.name, ".busy"},        32'(bus.busy),        32'(v.expBusy));
  endtask

  // Every output must read zero while reset is low.
  task automatic checkReset(input string name);
    checkSignal({name, ".if_gnt"},      32'(bus.if_gnt),      32'd0);
    checkSignal({name, ".ls_gnt"},      32'(bus.ls_gnt),      32'd0);
    checkSignal({name, ".if_valid"},    32'(bus.if_valid),    32'd0);
    checkSignal({name, ".ls_valid"},    32'(bus.ls_valid),    32'd0);
    checkSignal({name, ".if_err"},      32'(bus.if_err),      32'd0);
    checkSignal({name, ".ls_err"},      32'(bus.ls_err),      32'd0);
    checkSignal({name, ".if_rdata"},    bus.if_rdata,         32'd0);
    checkSignal({name, ".ls_rdata"},    bus.ls_rdata,         32'd0);
    checkSignal({name, ".mem_request"}, 32'(bus.mem_request), 32'd0);
    checkSignal({name, ".mem_we_re"},   32'(bus.mem_we_re),   32'd0);
    checkSignal({name, ".mem_mask"},    32'(bus.mem_mask),    32'd0);
    checkSignal({name, ".mem_address"}, 32'(bus.mem_address), 32'd0);
    checkSignal({name, ".mem_data_in"}, bus.mem_data_in,      32'd0);
    checkSignal({name, ".busy"},        32'(bus.busy),        32'd0);
  endtask

  // Holds reset for two cycles with both requests raised, so the grants are
  // also seen to stay low under reset. Returns with reset still asserted.
  task automatic resetDut(input string name);
    @(negedge clk);
    rst = 1'b0;
    clearInputs();
    bus.if_req = 1'b1;
    bus.ls_req = 1'b1;
    #1;
    checkReset({name, "_async"});
    @(negedge clk);
    #1;
    checkReset({name, "_held"});
  endtask

  // Watchdog so a stuck DUT still ends the run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  busyCycles;
    bit  finished;

    vecs[0]  = '{"fetch_gnt",   1'b1, 12'h010, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 32'h0,
                 2'b10, 2'b00, 2'b00, 32'h0,        32'h0,        1'b0, 1'b0, 4'h0, 12'h000, 32'h0,        1'b0};
    vecs[1]  = '{"fetch_issue", 1'b0, 12'h010, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 32'h0,
                 2'b00, 2'b00, 2'b00, 32'h0,        32'h0,        1'b1, 1'b0, 4'hF, 12'h010, 32'h0,        1'b1};
    vecs[2]  = '{"fetch_wait",  1'b0, 12'h010, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 32'hDEADBEEF,
                 2'b00, 2'b00, 2'b00, 32'h0,        32'h0,        1'b0, 1'b0, 4'hF, 12'h010, 32'h0,        1'b1};
    vecs[3]  = '{"fetch_done",  1'b0, 12'h010, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 32'h0,
                 2'b00, 2'b10, 2'b00, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 4'hF, 12'h010, 32'h0,        1'b0};
    vecs[4]  = '{"fetch_idle",  1'b0, 12'h010, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 32'h0,
                 2'b00, 2'b00, 2'b00, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 4'hF, 12'h010, 32'h0,        1'b0};
    vecs[5]  = '{"load_gnt",    1'b0, 12'h010, 1'b1, 1'b0, 4'hF, 12'h020, 32'h0,        1'b0, 32'h0,
                 2'b01, 2'b00, 2'b00, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 4'hF, 12'h010, 32'h0,        1'b0};
    vecs[6]  = '{"load_issue",  1'b0, 12'h010, 1'b0, 1'b0, 4'hF, 12'h020, 32'h0,        1'b0, 32'h0,
                 2'b00, 2'b00, 2'b00, 32'hDEADBEEF, 32'h0,        1'b1, 1'b0, 4'hF, 12'h020, 32'h0,        1'b1};
    vecs[7]  = '{"load_wait",   1'b0, 12'h010, 1'b0, 1'b0, 4'hF, 12'h020, 32'h0,        1'b1, 32'h55AA1234,
                 2'b00, 2'b00, 2'b00, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 4'hF, 12'h020, 32'h0,        1'b1};
    vecs[8]  = '{"load_done",   1'b0, 12'h010, 1'b0, 1'b0, 4'hF, 12'h020, 32'h0,        1'b0, 32'h0,
                 2'b00, 2'b01, 2'b00, 32'hDEADBEEF, 32'h55AA1234, 1'b0, 1'b0, 4'hF, 12'h020, 32'h0,        1'b0};
    vecs[9]  = '{"store_gnt",   1'b0, 12'h010, 1'b1, 1'b1, 4'h3, 12'h0FF, 32'h1234ABCD, 1'b0, 32'h0,
                 2'b01, 2'b00, 2'b00, 32'hDEADBEEF, 32'h55AA1234, 1'b0, 1'b0, 4'hF, 12'h020, 32'h0,        1'b0};
    vecs[10] = '{"store_issue", 1'b0, 12'h010, 1'b0, 1'b1, 4'h3, 12'h0FF, 32'h1234ABCD, 1'b0, 32'h0,
                 2'b00, 2'b00, 2'b00, 32'hDEADBEEF, 32'h55AA1234, 1'b1, 1'b1, 4'h3, 12'h0FF, 32'h1234ABCD, 1'b1};
    vecs[11] = '{"store_wait",  1'b0, 12'h010, 1'b0, 1'b1, 4'h3, 12'h0FF, 32'h1234ABCD, 1'b1, 32'hCAFEF00D,
                 2'b00, 2'b00, 2'b00, 32'hDEADBEEF, 32'h55AA1234, 1'b0, 1'b1, 4'h3, 12'h0FF, 32'h1234ABCD, 1'b1};
    vecs[12] = '{"store_done",  1'b0, 12'h010, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 32'h0,
                 2'b00, 2'b01, 2'b00, 32'hDEADBEEF, 32'h55AA1234, 1'b0, 1'b1, 4'h3, 12'h0FF, 32'h1234ABCD, 1'b0};
    vecs[13] = '{"stray_valid", 1'b0, 12'h010, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 32'h0BADF00D,
                 2'b00, 2'b00, 2'b00, 32'hDEADBEEF, 32'h55AA1234, 1'b0, 1'b1, 4'h3, 12'h0FF, 32'h1234ABCD, 1'b0};
    vecs[14] = '{"stray_after", 1'b0, 12'h010, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 32'h0,
                 2'b00, 2'b00, 2'b00, 32'hDEADBEEF, 32'h55AA1234, 1'b0, 1'b1, 4'h3, 12'h0FF, 32'h1234ABCD, 1'b0};

    rst = 1'b0;
    clearInputs();

    // Table-driven fetch / load / store / stray-response vectors.
    resetDut("reset0");
    @(negedge clk);
    rst = 1'b1;
    clearInputs();
    for (int i = 0; i < NumVecs; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i]);
    end

    // Tie from reset: both held, memory answering at once. Load/store wins
    // first, then fetch, then load/store, one grant every three cycles. The
    // requests are present on the release edge, so the first grant is
    // visible immediately.
    resetDut("reset1");
    @(negedge clk);
    rst              = 1'b1;
    bus.if_req       = 1'b1;
    bus.if_addr      = 12'h100;
    bus.ls_req       = 1'b1;
    bus.ls_we_re     = 1'b0;
    bus.ls_mask      = 4'hF;
    bus.ls_addr      = 12'h200;
    bus.ls_wdata     = 32'd0;
    bus.mem_valid    = 1'b1;
    bus.mem_data_out = 32'h11112222;
    for (int k = 0; k < 9; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      checkSignal($sformatf("tie_c%0d.if_gnt", k),   32'(bus.if_gnt),   32'(k == 3));
      checkSignal($sformatf("tie_c%0d.ls_gnt", k),   32'(bus.ls_gnt),   32'(k == 0 || k == 6));
      checkSignal($sformatf("tie_c%0d.if_valid", k), 32'(bus.if_valid), 32'(k == 6));
      checkSignal($sformatf("tie_c%0d.ls_valid", k), 32'(bus.ls_valid), 32'(k == 3));
      if (k == 1 || k == 7) begin
        checkSignal($sformatf("tie_c%0d.mem_address", k), 32'(bus.mem_address), 32'h200);
      end
      if (k == 4) begin
        checkSignal("tie_c4.mem_address", 32'(bus.mem_address), 32'h100);
      end
    end
    @(negedge clk);
    clearInputs();
    #1;
    checkSignal("tie_end.ls_valid", 32'(bus.ls_valid), 32'd1);
    checkSignal("tie_end.if_valid", 32'(bus.if_valid), 32'd0);
    checkSignal("tie_end.if_rdata", bus.if_rdata,      32'h11112222);
    checkSignal("tie_end.ls_rdata", bus.ls_rdata,      32'h11112222);
    checkSignal("tie_end.busy",     32'(bus.busy),     32'd0);

    // Timeout: memory never answers. Busy covers one ISSUE cycle plus
    // TIMEOUT wait cycles, then fetch completes with err and zeroed data.
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 12'h033;
    #1;
    checkSignal("timeout_gnt.if_gnt", 32'(bus.if_gnt), 32'd1);
    checkSignal("timeout_gnt.ls_gnt", 32'(bus.ls_gnt), 32'd0);
    busyCycles = 0;
    finished   = 1'b0;
    for (int c = 0; c < 40 && !finished; c++) begin
      @(negedge clk);
      bus.if_req = 1'b0;
      #1;
      if (bus.busy) begin
        busyCycles++;
        checkSignal($sformatf("timeout_c%0d.if_valid", c), 32'(bus.if_valid), 32'd0);
      end else begin
        finished = 1'b1;
      end
    end
    checkSignal("timeout.completed",   32'(finished),   32'd1);
    checkSignal("timeout.busy_cycles", 32'(busyCycles), 32'(TIMEOUT + 1));
    checkSignal("timeout.if_valid",    32'(bus.if_valid), 32'd1);
    checkSignal("timeout.if_err",      32'(bus.if_err),   32'd1);
    checkSignal("timeout.if_rdata",    bus.if_rdata,      32'd0);
    checkSignal("timeout.ls_valid",    32'(bus.ls_valid), 32'd0);
    checkSignal("timeout.ls_rdata",    bus.ls_rdata,      32'h11112222);

    // Reset while a load waits: everything clears, no completion appears,
    // and a response arriving after reset is ignored.
    @(negedge clk);
    bus.ls_req   = 1'b1;
    bus.ls_we_re = 1'b0;
    bus.ls_mask  = 4'hF;
    bus.ls_addr  = 12'h044;
    #1;
    checkSignal("rstwait_gnt.ls_gnt", 32'(bus.ls_gnt), 32'd1);
    @(negedge clk);
    bus.ls_req = 1'b0;
    #1;
    checkSignal("rstwait_issue.mem_request", 32'(bus.mem_request), 32'd1);
    @(negedge clk);
    #1;
    checkSignal("rstwait_wait.busy", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    #1;
    checkReset("rstwait_in_reset");
    @(negedge clk);
    rst              = 1'b1;
    bus.mem_valid    = 1'b1;
    bus.mem_data_out = 32'h77777777;
    for (int c = 0; c < 3; c++) begin
      #1;
      checkSignal($sformatf("rstwait_after%0d.ls_valid", c), 32'(bus.ls_valid), 32'd0);
      checkSignal($sformatf("rstwait_after%0d.if_valid", c), 32'(bus.if_valid), 32'd0);
      checkSignal($sformatf("rstwait_after%0d.busy", c),     32'(bus.busy),     32'd0);
      checkSignal($sformatf("rstwait_after%0d.ls_rdata", c), bus.ls_rdata,      32'd0);
      @(negedge clk);
      bus.mem_valid = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
